// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver, 8x oversampled with majority vote, feeding a show-ahead byte FIFO
module uart_rx_fifo #(
   parameter int OVERSAMPLE = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          rx,
   output logic [7:0]                    rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic                          framing_error,
   output logic                          overrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [2:0]       TICK_LAST = 3'(OVERSAMPLE - 1);
   localparam logic [2:0]       TICK_S0   = 3'd3;
   localparam logic [2:0]       TICK_S1   = 3'd4;
   localparam logic [2:0]       TICK_S2   = 3'd5;
   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic             rx_meta_q, rx_meta_d;
   logic             rx_s_q, rx_s_d;
   logic [2:0]       tick_q, tick_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             samp0_q, samp0_d;
   logic             samp1_q, samp1_d;
   logic             fe_q, fe_d;
   logic             ov_q, ov_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [7:0]       mem_q [FIFO_DEPTH];

   logic             maj;
   logic             push;
   logic             pop;
   logic             accept;

   // third sample is taken live from rx_s at tick 5, the first two are held
   assign maj = (samp0_q & samp1_q) | (samp0_q & rx_s_q) | (samp1_q & rx_s_q);

   always_comb begin
      rx_meta_d = rx;
      rx_s_d    = rx_meta_q;
      state_d   = state_q;
      tick_d    = tick_q + 3'd1;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      samp0_d   = samp0_q;
      samp1_d   = samp1_q;
      fe_d      = 1'b0;
      push      = 1'b0;

      if (tick_q == TICK_S0) samp0_d = rx_s_q;
      if (tick_q == TICK_S1) samp1_d = rx_s_q;

      case (state_q)
         S_IDLE: begin
            tick_d = 3'd0;
            if (!rx_s_q) begin
               state_d = S_START;
               tick_d  = 3'd1;
            end
         end
         S_START: begin
            if (tick_q == TICK_S2 && maj) begin
               state_d = S_IDLE;
               tick_d  = 3'd0;
            end else if (tick_q == TICK_LAST) begin
               state_d   = S_DATA;
               bit_idx_d = 3'd0;
            end
         end
         S_DATA: begin
            if (tick_q == TICK_S2) shift_d = {maj, shift_q[7:1]};
            if (tick_q == TICK_LAST) begin
               if (bit_idx_q == 3'd7) state_d = S_STOP;
               else                   bit_idx_d = bit_idx_q + 3'd1;
            end
         end
         S_STOP: begin
            // leave at mid-stop so the next start edge can be caught early
            if (tick_q == TICK_S2) begin
               tick_d = 3'd0;
               if (maj) begin
                  push    = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  fe_d    = 1'b1;
                  state_d = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            tick_d = 3'd0;
            if (rx_s_q) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            tick_d  = 3'd0;
         end
      endcase
   end

   always_comb begin
      pop      = rx_valid & rx_ready;
      accept   = push & ((count_q != DEPTH_C) | pop);
      ov_d     = push & ~accept;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d  = count_q + CNT_W'(accept) - CNT_W'(pop);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         state_q   <= S_IDLE;
         tick_q    <= 3'd0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'd0;
         samp0_q   <= 1'b1;
         samp1_q   <= 1'b1;
         fe_q      <= 1'b0;
         ov_q      <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         rx_meta_q <= rx_meta_d;
         rx_s_q    <= rx_s_d;
         state_q   <= state_d;
         tick_q    <= tick_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         samp0_q   <= samp0_d;
         samp1_q   <= samp1_d;
         fe_q      <= fe_d;
         ov_q      <= ov_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

   // storage needs no reset; rx_data is masked while the FIFO is empty
   always_ff @(posedge clk) begin
      if (accept) mem_q[wr_ptr_q] <= shift_q;
   end

   assign rx_valid      = (count_q != '0);
   assign rx_data       = rx_valid ? mem_q[rd_ptr_q] : 8'd0;
   assign framing_error = fe_q;
   assign overrun       = ov_q;
   assign fifo_count    = count_q;

endmodule
